md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage, beside alu. Both blocks take the same

---
 rtl/md_unit_pkg.sv | 17 +
 rtl/md_unit_calc.sv | 30 +++
 rtl/md_unit.sv | 62 ++++++
 tb/tb_md_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: MDCtrl opcode encodings and default widths/latencies for the multiply/divide unit
package md_unit_pkg;
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_ctrl_e;
    localparam int MD_WIDTH       = 32;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
endpackage

// File: rtl/md_unit_calc.sv
// md_unit_calc: combinational signed/unsigned multiply and divide producing {hi,lo} and a div0 flag
module md_unit_calc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    input  logic             i_div,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div0
);
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_safe, w_q, w_r;
    logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
    assign w_a_ext  = {{WIDTH{i_signed & i_a[WIDTH-1]}}, i_a};
    assign w_b_ext  = {{WIDTH{i_signed & i_b[WIDTH-1]}}, i_b};
    assign w_prod   = w_a_ext * w_b_ext;
    // Divide on magnitudes so MIN/-1 wraps to MIN instead of overflowing
    assign w_a_neg  = i_signed & i_a[WIDTH-1];
    assign w_b_neg  = i_signed & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;
    assign o_div0   = i_div && i_b == '0;
    assign w_b_safe = o_div0 ? WIDTH'(1) : w_b_mag;
    assign w_q      = w_a_mag / w_b_safe;
    assign w_r      = w_a_mag % w_b_safe;
    assign o_lo     = i_div ? ((w_a_neg ^ w_b_neg) ? -w_q : w_q) : w_prod[WIDTH-1:0];
    assign o_hi     = i_div ? (w_a_neg ? -w_r : w_r) : w_prod[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO; results commit after a fixed busy latency
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = MD_WIDTH,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       MDCtrl,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDOut
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_shadow;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi, r_lo, w_hi, w_lo;
    logic               w_div0, w_is_mul, w_is_div, w_launch;
    assign w_is_mul = MDCtrl == MD_MULT || MDCtrl == MD_MULTU;
    assign w_is_div = MDCtrl == MD_DIV || MDCtrl == MD_DIVU;
    assign busy     = r_cnt != '0;
    assign w_launch = start && !busy && (w_is_mul || w_is_div);
    md_unit_calc #(.WIDTH(WIDTH)) u_calc (
        .i_a      (SrcA),
        .i_b      (SrcB),
        .i_signed (MDCtrl == MD_MULT || MDCtrl == MD_DIV),
        .i_div    (w_is_div),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_div0   (w_div0)
    );
    // Result is captured at launch; the counter only models latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_launch) begin
            r_cnt    <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_shadow <= {w_hi, w_lo};
            r_div0   <= w_div0;
        end else if (busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1) && !r_div0) {r_hi, r_lo} <= r_shadow;
        end else begin
            if (MDCtrl == MD_MTHI) r_hi <= SrcA;
            if (MDCtrl == MD_MTLO) r_lo <= SrcA;
        end
    end
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign MDOut = MDCtrl == MD_MFHI ? r_hi : MDCtrl == MD_MFLO ? r_lo : '0;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus with a cycle-level reference model and hand-computed expectations
module tb_md_unit;
    import md_unit_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic [3:0]  MDCtrl = MD_NONE;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDOut;
    int n_pass = 0, n_tot = 0;
    bit chk_en = 1'b0;
    md_unit dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDCtrl(MDCtrl),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask
    // Reference: architectural HI/LO plus remaining latency and the result due at completion
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_rem = 0;
    bit          m_pend = 1'b0;
    logic [63:0] m_res = '0;
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        sa = a;
        sb = b;
        case (op)
            MD_MULT:  begin p = longint'(sa) * longint'(sb); return p; end
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV:   return (a == 32'h80000000 && b == 32'hFFFFFFFF) ? {32'h0, 32'h80000000}
                                                                     : {32'(sa % sb), 32'(sa / sb)};
            default:  return {a % b, a / b};
        endcase
    endfunction
    always @(posedge clk) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_pend = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pend) {m_hi, m_lo} = m_res;
        end else if (start && MDCtrl inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
            m_rem  = MDCtrl inside {MD_DIV, MD_DIVU} ? MD_DIV_CYCLES : MD_MULT_CYCLES;
            m_pend = !(MDCtrl inside {MD_DIV, MD_DIVU} && SrcB == 0);
            if (m_pend) m_res = ref_res(MDCtrl, SrcA, SrcB);
        end else if (MDCtrl == MD_MTHI) m_hi = SrcA;
        else if (MDCtrl == MD_MTLO) m_lo = SrcA;
    end
    always @(negedge clk) if (chk_en) begin
        chk("busy", {31'b0, busy}, {31'b0, m_rem > 0});
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        chk("MDOut", MDOut, MDCtrl == MD_MFHI ? m_hi : MDCtrl == MD_MFLO ? m_lo : 32'h0);
    end
    task automatic step(input logic rn, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
        reset = rn; MDCtrl = op; SrcA = a; SrcB = b; start = st;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        step(1'b1, MD_NONE, 32'h0, 32'h0, 1'b0);
    endtask
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        step(1'b1, op, a, b, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            idle();
            n++;
        end
        chk({name, " latency"}, n, lat);
        chk({name, " HI"}, HI, ehi);
        chk({name, " LO"}, LO, elo);
    endtask
    initial begin
        step(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, MD_MTHI, $urandom, 32'h0, 1'b0);
        step(1'b1, MD_MTLO, $urandom | 32'h1, 32'h0, 1'b0);
        step(1'b0, MD_MFHI, 32'h0, 32'h0, 1'b0);
        step(1'b0, MD_MFHI, 32'h0, 32'h0, 1'b0);
        chk("reset HI", HI, 32'h0);
        chk("reset LO", LO, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset MDOut", MDOut, 32'h0);
        run_op("mult",  MD_MULT,  32'hFFFFFFFF, 32'h2, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 5,  32'h00000001, 32'hFFFFFFFE);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0", MD_DIVU,  32'h7,        32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divov", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        run_op("divneg", MD_DIV,  32'h7,        32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD);
        run_op("divu",  MD_DIVU,  32'hFFFFFFF9, 32'h2, 10, 32'h1, 32'h7FFFFFFC);
        step(1'b1, MD_MFLO, 32'h5, 32'h5, 1'b1);
        chk("nonmd start busy", {31'b0, busy}, 32'h0);
        step(1'b1, MD_MULT, 32'h3, 32'hFFFFFFFC, 1'b1);
        step(1'b1, MD_MULT, 32'h100, 32'h100, 1'b1);
        idle();
        step(1'b1, MD_DIV, 32'h9, 32'h3, 1'b1);
        step(1'b1, MD_MTLO, 32'h1234, 32'h0, 1'b0);
        chk("relaunch busy", {31'b0, busy}, 32'h1);
        chk("mtlo busy LO", LO, 32'h7FFFFFFC);
        idle();
        chk("relaunch done", {31'b0, busy}, 32'h0);
        chk("relaunch HI", HI, 32'hFFFFFFFF);
        chk("relaunch LO", LO, 32'hFFFFFFF4);
        step(1'b1, MD_MTHI, 32'hAAAA, 32'h0, 1'b0);
        step(1'b1, MD_MTLO, 32'h5555, 32'h0, 1'b0);
        step(1'b1, MD_DIV, 32'd100, 32'd7, 1'b1);
        idle();
        idle();
        step(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
        chk("midreset busy", {31'b0, busy}, 32'h0);
        chk("midreset HI", HI, 32'h0);
        chk("midreset LO", LO, 32'h0);
        for (int i = 0; i < 12; i++) idle();
        chk("no late HI", HI, 32'h0);
        chk("no late LO", LO, 32'h0);
        step(1'b1, MD_MTHI, 32'hCAFE0000, 32'h0, 1'b0);
        step(1'b1, MD_MFHI, 32'h0, 32'h0, 1'b0);
        chk("mfhi", MDOut, 32'hCAFE0000);
        step(1'b1, MD_MTLO, 32'h0BADF00D, 32'h0, 1'b0);
        step(1'b1, MD_MULT, 32'h2, 32'h3, 1'b1);
        step(1'b1, MD_MFLO, 32'h0, 32'h0, 1'b0);
        chk("mflo busy", MDOut, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) idle();
        step(1'b1, MD_MFLO, 32'h0, 32'h0, 1'b0);
        chk("mflo after", MDOut, 32'h6);
        idle();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
